keysched_iter: RTL and testbench
================================

Name: keysched_iter

Overview:
Word-serial AES key-schedule generator with runtime-selectable key length (128/192/256). It produces the full expanded key w[0..Nb*(Nr+1)-1], one 32-bit word per accepted handshake, from a single start command. It supersedes per-word unrolled expansion stages and feeds round-key registers or a key RAM upstream of the cipher core. Output uses valid/ready backpressure so the consumer can stall at any word.

Parameters:
WORD, 32, word width in bits; only 32 is supported.
NB, 4, state columns; fixes the round-key size at NB words.
MAXNK, 8, maximum key length in words; sets the i_key width and window depth.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
i_start  in  1  start pulse; sampled only in IDLE
i_keylen  in  2  0=AES-128 (Nk=4), 1=AES-192 (Nk=6), 2=AES-256 (Nk=8), 3=treated as 0
i_key  in  MAXNK*WORD  cipher key; w0 in bits [255:224]; unused low words are ignored
i_ready  in  1  consumer ready
o_valid  out  1  o_wi/o_idx/o_last valid
o_wi  out  WORD  expanded key word w[o_idx]
o_idx  out  6  word index, 0..59
o_last  out  1  high with the final word (idx 43/51/59)
o_busy  out  1  high from start acceptance until the final handshake
o_done  out  1  one-cycle pulse in the cycle after the final handshake

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; o_valid, o_busy, o_done, o_last = 0; o_idx, o_wi = 0; rcon = 0x01. Reset mid-run aborts immediately, with no further output.
- Derived values: Nk from the latched keylen; Nr = Nk+6; total = 4*(Nr+1), giving 44, 52 or 60.
- States:
  - IDLE: on i_start=1, latch key into window win[0..Nk-1] (win[0]=w0), latch Nk, set idx=0, jmod=0, rcon=0x01, and go to EMIT. o_busy rises in the next cycle.
  - EMIT: o_valid=1. Transfer occurs when o_valid and i_ready are both high.
  - DONE: one cycle with o_done=1 and o_busy=0, then IDLE.
- Start-to-first-word latency is 1 cycle: o_valid is high in the cycle after i_start is sampled.
- i_start is ignored while o_busy=1 and in DONE.
- For idx < Nk: o_wi = win[idx]. The window does not shift on these transfers.
- For idx >= Nk, combinationally from the registered window, with prev = win[Nk-1] = w[i-1] and old = win[0] = w[i-Nk]:
  - jmod==0: o_wi = old ^ SubWord(RotWord(prev)) ^ {rcon,24'h0}
  - Nk==8 and jmod==4: o_wi = old ^ SubWord(prev)
  - otherwise: o_wi = old ^ prev
- On each transfer with idx >= Nk:
  - win[k] <= win[k+1] for k < Nk-1; win[Nk-1] <= o_wi.
  - jmod <= (jmod==Nk-1) ? 0 : jmod+1.
  - If jmod was 0: rcon <= xtime(rcon), i.e. (rcon<<1) ^ (rcon[7] ? 0x1b : 0).
- On every transfer, idx increments. At idx==Nk-1, jmod restarts at 0 for the first derived word.
- Stall: while i_ready=0, o_wi, o_idx, o_last and o_valid are held stable. No state changes.
- o_last = (idx == total-1) && o_valid. A transfer on o_last moves to DONE and drops o_valid in the next cycle.
- SubWord is 4 parallel S-box instances on a single shared path. It is purely combinational, with no added pipeline.
- rcon never exceeds 0x36 for valid key lengths: at most 10 rcon uses, at Nk=4.

Test Plan:
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, i_ready=1 -> first o_valid 1 cycle after start; w4=a0fafe17; w43=b6630ca6 with o_last=1; 44 transfers; o_done pulses once.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> w6=fe0c91f7; w51=01002202 with o_last; 52 transfers.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w8=9ba35411; w59=706c631e; exercises the jmod==4 SubWord path.
- AES-128 with random i_ready (~50% duty) -> same 44 words in order; outputs held stable during every stall; no duplicated or skipped idx.
- i_start pulsed mid-run, and i_keylen=3 -> mid-run start ignored and current run unchanged; keylen=3 produces the AES-128 sequence.
- rst=0 at idx=20 of an AES-256 run -> next cycle all outputs 0 and state IDLE; a fresh start then yields a correct w0..w59.

Source files
------------

// File: rtl/keysched_iter.sv
// Word-serial AES key expansion for 128/192/256-bit keys, one 32-bit word per valid/ready transfer.
// States: S_IDLE | waiting for start ; S_EMIT | presenting w[idx] ; S_DONE | one-cycle completion pulse
module keysched_iter #(
    parameter int WORD  = 32,
    parameter int NB    = 4,
    parameter int MAXNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [1:0]            i_keylen,
    input  logic [MAXNK*WORD-1:0] i_key,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [WORD-1:0]       o_wi,
    output logic [5:0]            o_idx,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t          state_q, state_d;
    logic [WORD-1:0] win_q [MAXNK];
    logic [WORD-1:0] win_d [MAXNK];
    logic [3:0]      nk_q, nk_d;
    logic [5:0]      idx_q, idx_d;
    logic [2:0]      jmod_q, jmod_d;
    logic [7:0]      rcon_q, rcon_d;

    logic [3:0]      nk_sel;
    logic [5:0]      total;
    logic [5:0]      last_idx;
    logic            derived;
    logic            emit;
    logic [WORD-1:0] prev;
    logic [WORD-1:0] sel;
    logic [WORD-1:0] sub_in;
    logic [WORD-1:0] sub_out;
    logic [WORD-1:0] wi;

    always_comb begin
        case (i_keylen)
            2'd1:    nk_sel = 4'd6;
            2'd2:    nk_sel = 4'd8;
            default: nk_sel = 4'd4;
        endcase
    end

    assign total    = 6'(NB * (int'(nk_q) + 7));
    assign last_idx = total - 6'd1;
    assign derived  = idx_q >= {2'b00, nk_q};
    assign emit     = state_q == S_EMIT;

    // prev is the newest word in the window; one S-box row serves both the rotated and plain SubWord cases
    always_comb begin
        prev = win_q[0];
        sel  = win_q[0];
        for (int k = 0; k < MAXNK; k++) begin
            if (4'(k + 1) == nk_q) prev = win_q[k];
            if (6'(k) == idx_q)    sel  = win_q[k];
        end
        sub_in  = (jmod_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
        if (!derived)
            wi = sel;
        else if (jmod_q == 3'd0)
            wi = win_q[0] ^ sub_out ^ {rcon_q, 24'h000000};
        else if (nk_q == 4'd8 && jmod_q == 3'd4)
            wi = win_q[0] ^ sub_out;
        else
            wi = win_q[0] ^ prev;
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        nk_d    = nk_q;
        idx_d   = idx_q;
        jmod_d  = jmod_q;
        rcon_d  = rcon_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    for (int k = 0; k < MAXNK; k++)
                        win_d[k] = i_key[WORD*(MAXNK-k)-1 -: WORD];
                    nk_d    = nk_sel;
                    idx_d   = 6'd0;
                    jmod_d  = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (i_ready) begin
                    idx_d = idx_q + 6'd1;
                    if (derived) begin
                        for (int k = 0; k < MAXNK - 1; k++)
                            if (4'(k + 1) < nk_q) win_d[k] = win_q[k+1];
                        for (int k = 0; k < MAXNK; k++)
                            if (4'(k + 1) == nk_q) win_d[k] = wi;
                        jmod_d = ({1'b0, jmod_q} == nk_q - 4'd1) ? 3'd0 : jmod_q + 3'd1;
                        if (jmod_q == 3'd0)
                            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    end
                    if (idx_q == last_idx) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < MAXNK; k++) win_q[k] <= '0;
            nk_q    <= 4'd4;
            idx_q   <= 6'd0;
            jmod_q  <= 3'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < MAXNK; k++) win_q[k] <= win_d[k];
            nk_q    <= nk_d;
            idx_q   <= idx_d;
            jmod_q  <= jmod_d;
            rcon_q  <= rcon_d;
        end
    end

    assign o_valid = emit;
    assign o_wi    = emit ? wi : '0;
    assign o_idx   = emit ? idx_q : 6'd0;
    assign o_last  = emit && (idx_q == last_idx);
    assign o_busy  = emit;
    assign o_done  = state_q == S_DONE;

endmodule

// File: tb/tb_keysched_iter.sv
// Directed bench for keysched_iter: FIPS-197 key vectors, random backpressure, mid-run start and abort.
module tb_keysched_iter;

    logic         clk;
    logic         rst;
    logic         i_start;
    logic [1:0]   i_keylen;
    logic [255:0] i_key;
    logic         i_ready;
    logic         o_valid;
    logic [31:0]  o_wi;
    logic [5:0]   o_idx;
    logic         o_last;
    logic         o_busy;
    logic         o_done;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_w [0:59];
    logic [31:0] obs_w [0:59];

    localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'hdeadbeef_cafef00d_12345678_9abcdef0};
    localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'ha5a5a5a5_5a5a5a5a};
    localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    keysched_iter dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_keylen (i_keylen),
        .i_key    (i_key),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_wi     (o_wi),
        .o_idx    (o_idx),
        .o_last   (o_last),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box built from the GF(2^8) inverse and affine map rather than a lookup table
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) exp_w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    task automatic start_run(input logic [1:0] kl, input logic [255:0] key);
        @(negedge clk);
        i_keylen = kl;
        i_key    = key;
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("first_valid", 32'(o_valid), 32'd1);
        check("busy_rise", 32'(o_busy), 32'd1);
    endtask

    task automatic collect(input int nk, input bit rnd, input int abort_at, input int mid_at);
        int          total;
        int          got;
        int          cyc;
        bit          stalled;
        bit          mid_done;
        logic [31:0] h_wi;
        logic [5:0]  h_idx;
        logic        h_last;
        total    = 4 * (nk + 7);
        got      = 0;
        cyc      = 0;
        stalled  = 1'b0;
        mid_done = 1'b0;
        while (got < total && cyc < 3000) begin
            if (stalled) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_wi", o_wi, h_wi);
                check("stall_idx", 32'(o_idx), 32'(h_idx));
                check("stall_last", 32'(o_last), 32'(h_last));
            end
            if (!o_valid) begin
                check("valid_in_run", 32'(o_valid), 32'd1);
                break;
            end
            if (got == abort_at) begin
                check("abort_idx", 32'(o_idx), 32'(abort_at));
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check("abort_valid", 32'(o_valid), 32'd0);
                check("abort_wi", o_wi, 32'd0);
                check("abort_idx0", 32'(o_idx), 32'd0);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_last", 32'(o_last), 32'd0);
                check("abort_done", 32'(o_done), 32'd0);
                @(negedge clk);
                check("abort_quiet", 32'(o_valid), 32'd0);
                return;
            end
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (got == mid_at && !mid_done) begin
                i_start  = 1'b1;
                i_keylen = 2'd2;
                i_key    = K256;
                mid_done = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            if (i_ready) begin
                check("busy", 32'(o_busy), 32'd1);
                check("idx", 32'(o_idx), 32'(got));
                check("word", o_wi, exp_w[got]);
                check("last", 32'(o_last), 32'(got == total - 1));
                obs_w[got] = o_wi;
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                h_wi    = o_wi;
                h_idx   = o_idx;
                h_last  = o_last;
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        check("transfers", 32'(got), 32'(total));
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_valid", 32'(o_valid), 32'd0);
        check("done_busy", 32'(o_busy), 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("done_once", 32'(o_done), 32'd0);
        check("idle_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        check("start_in_done_ignored", 32'(o_valid), 32'd0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        i_start  = 1'b0;
        i_keylen = 2'd0;
        i_key    = '0;
        i_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_idx", 32'(o_idx), 32'd0);
        check("rst_wi", o_wi, 32'd0);
        rst = 1'b1;

        expand(K128, 4);
        start_run(2'd0, K128);
        collect(4, 1'b0, -1, -1);
        check("a128_w4", obs_w[4], 32'ha0fafe17);
        check("a128_w43", obs_w[43], 32'hb6630ca6);

        expand(K192, 6);
        start_run(2'd1, K192);
        collect(6, 1'b0, -1, -1);
        check("a192_w6", obs_w[6], 32'hfe0c91f7);
        check("a192_w51", obs_w[51], 32'h01002202);

        expand(K256, 8);
        start_run(2'd2, K256);
        collect(8, 1'b0, -1, -1);
        check("a256_w8", obs_w[8], 32'h9ba35411);
        check("a256_w59", obs_w[59], 32'h706c631e);

        expand(K128, 4);
        start_run(2'd0, K128);
        collect(4, 1'b1, -1, -1);

        start_run(2'd3, K128);
        collect(4, 1'b0, -1, 10);
        check("kl3_w43", obs_w[43], 32'hb6630ca6);

        expand(K256, 8);
        start_run(2'd2, K256);
        collect(8, 1'b0, 20, -1);
        start_run(2'd2, K256);
        collect(8, 1'b0, -1, -1);
        check("rerun_w59", obs_w[59], 32'h706c631e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
